// File: rtl/skip_fifo.sv
// Show-ahead synchronous FIFO whose read consumes 1..DEPTH head words at once; flags registered from next count.
// Latency: write-to-rddata 1 cycle; rddata_o is combinational from the head pointer.
// Backpressure: writes while full are dropped unless a read frees space in the same cycle (overflow pulse); reads while empty flag underflow.
module skip_fifo #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              srst_i,
    input  logic              wr_i,
    input  logic [DWIDTH-1:0] wrdata_i,
    input  logic              rd_i,
    input  logic [AWIDTH:0]   skip_i,
    output logic [DWIDTH-1:0] rddata_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_empty_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH:0] AE_C    = (AWIDTH + 1)'(AE_LVL);
    localparam logic [AWIDTH:0] AF_C    = (AWIDTH + 1)'(AF_LVL);
    localparam logic [AWIDTH:0] ONE_C   = (AWIDTH + 1)'(1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic [AWIDTH:0]   cnt;
    logic [AWIDTH:0]   skip_eff;
    logic [AWIDTH:0]   rd_cnt;
    logic [AWIDTH:0]   cnt_nxt;
    logic              rd_eff;
    logic              wr_acc;

    always_comb begin
        rd_eff   = rd_i & ~empty_o;
        skip_eff = (skip_i == '0) ? ONE_C : skip_i;
        rd_cnt   = '0;
        // Oversized skips saturate at the stored count so the read pointer never passes the write pointer.
        if (rd_eff) begin
            rd_cnt = (skip_eff > cnt) ? cnt : skip_eff;
        end
        wr_acc  = wr_i & (~full_o | rd_eff);
        cnt_nxt = cnt + (AWIDTH + 1)'(wr_acc) - rd_cnt;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_empty_o <= 1'b1;
            almost_full_o  <= 1'b0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else if (srst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            empty_o        <= 1'b1;
            full_o         <= 1'b0;
            almost_empty_o <= 1'b1;
            almost_full_o  <= 1'b0;
            overflow_o     <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A DEPTH-word skip has zero low bits, which is the correct modulo-DEPTH advance.
            rd_ptr         <= rd_ptr + rd_cnt[AWIDTH-1:0];
            cnt            <= cnt_nxt;
            empty_o        <= (cnt_nxt == '0);
            full_o         <= (cnt_nxt == DEPTH_C);
            almost_empty_o <= (cnt_nxt <= AE_C);
            almost_full_o  <= (cnt_nxt >= AF_C);
            overflow_o     <= wr_i & full_o & ~rd_eff;
            underflow_o    <= rd_i & empty_o;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc && !srst_i) begin
            mem[wr_ptr] <= wrdata_i;
        end
    end

    assign rddata_o = mem[rd_ptr];
    assign usedw_o  = cnt;

endmodule

// File: tb/tb_skip_fifo.sv
// Randomized and directed bench for skip_fifo against a queue-based reference model.
module tb_skip_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic       clk_i;
    logic       arstn_i;
    logic       srst_i;
    logic       wr_i;
    logic [7:0] wrdata_i;
    logic       rd_i;
    logic [4:0] skip_i;
    logic [7:0] rddata_o;
    logic [4:0] usedw_o;
    logic       empty_o;
    logic       full_o;
    logic       almost_empty_o;
    logic       almost_full_o;
    logic       overflow_o;
    logic       underflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] q[$];
    bit         m_ovf;
    bit         m_udf;

    skip_fifo #(.DWIDTH(8), .AWIDTH(4), .AF_LVL(AF), .AE_LVL(AE)) dut (
        .clk_i          (clk_i),
        .arstn_i        (arstn_i),
        .srst_i         (srst_i),
        .wr_i           (wr_i),
        .wrdata_i       (wrdata_i),
        .rd_i           (rd_i),
        .skip_i         (skip_i),
        .rddata_o       (rddata_o),
        .usedw_o        (usedw_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .almost_empty_o (almost_empty_o),
        .almost_full_o  (almost_full_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: a plain queue of stored words; updates once per clock edge, then the DUT is sampled 1ns later.
    task automatic step(input bit wr, input logic [7:0] d, input bit rd, input logic [4:0] skip, input bit srst);
        int  n;
        bit  full;
        bit  empty;
        bit  rde;
        bit  wacc;
        if (srst) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            empty = (q.size() == 0);
            full  = (q.size() == DEPTH);
            rde   = rd && !empty;
            n     = (skip == 0) ? 1 : int'(skip);
            if (n > q.size()) n = q.size();
            if (!rde) n = 0;
            wacc  = wr && (!full || rde);
            m_ovf = wr && full && !rde;
            m_udf = rd && empty;
            repeat (n) void'(q.pop_front());
            if (wacc) q.push_back(d);
        end
        wr_i     = wr;
        wrdata_i = d;
        rd_i     = rd;
        skip_i   = skip;
        srst_i   = srst;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        n_tests++; if (usedw_o !== 5'd0) begin n_fail++; $display("FAIL reset_usedw got=%0d exp=0", usedw_o); end
        n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
        n_tests++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full_o); end
        n_tests++; if (almost_empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_aempty got=%b exp=1", almost_empty_o); end
        n_tests++; if (almost_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_afull got=%b exp=0", almost_full_o); end
        n_tests++; if ({overflow_o, underflow_o} !== 2'b00) begin n_fail++; $display("FAIL reset_errs got=%b%b exp=00", overflow_o, underflow_o); end
    endtask

    task automatic test_fill();
        step(0, 8'h00, 0, 5'd0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1, 8'(i), 0, 5'd0, 0);
            n_tests++; if (usedw_o !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_usedw i=%0d got=%0d exp=%0d", i, usedw_o, i + 1); end
            n_tests++; if (almost_full_o !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, almost_full_o, (i + 1 >= AF)); end
            n_tests++; if (full_o !== (i == DEPTH - 1)) begin n_fail++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full_o, (i == DEPTH - 1)); end
        end
        step(1, 8'hEE, 0, 5'd0, 0);
        n_tests++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got=%b exp=1", overflow_o); end
        n_tests++; if (usedw_o !== 5'd16) begin n_fail++; $display("FAIL ovf_usedw got=%0d exp=16", usedw_o); end
        step(0, 8'h00, 0, 5'd0, 0);
        n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_single got=%b exp=0", overflow_o); end
        n_tests++; if (rddata_o !== 8'h00) begin n_fail++; $display("FAIL ovf_head got=%h exp=00", rddata_o); end
    endtask

    task automatic test_skip();
        step(0, 8'h00, 1, 5'd3, 0);
        n_tests++; if (usedw_o !== 5'd13) begin n_fail++; $display("FAIL skip3_usedw got=%0d exp=13", usedw_o); end
        n_tests++; if (rddata_o !== 8'h03) begin n_fail++; $display("FAIL skip3_data got=%h exp=03", rddata_o); end
        step(0, 8'h00, 1, 5'd0, 0);
        n_tests++; if (usedw_o !== 5'd12) begin n_fail++; $display("FAIL skip0_usedw got=%0d exp=12", usedw_o); end
        n_tests++; if (rddata_o !== 8'h04) begin n_fail++; $display("FAIL skip0_data got=%h exp=04", rddata_o); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 4; i++) step(1, 8'(8'h20 + i), 0, 5'd0, 0);
        n_tests++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL frw_full got=%b exp=1", full_o); end
        step(1, 8'h55, 1, 5'd1, 0);
        n_tests++; if (usedw_o !== 5'd16) begin n_fail++; $display("FAIL frw_usedw got=%0d exp=16", usedw_o); end
        n_tests++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL frw_ovf got=%b exp=0", overflow_o); end
        n_tests++; if (rddata_o !== 8'h05) begin n_fail++; $display("FAIL frw_head got=%h exp=05", rddata_o); end
    endtask

    task automatic test_saturate();
        step(0, 8'h00, 0, 5'd0, 1);
        step(1, 8'h61, 0, 5'd0, 0);
        step(1, 8'h62, 0, 5'd0, 0);
        step(0, 8'h00, 1, 5'd5, 0);
        n_tests++; if (usedw_o !== 5'd0) begin n_fail++; $display("FAIL sat_usedw got=%0d exp=0", usedw_o); end
        n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL sat_empty got=%b exp=1", empty_o); end
        n_tests++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL sat_udf got=%b exp=0", underflow_o); end
        step(0, 8'h00, 1, 5'd1, 0);
        n_tests++; if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL udf_pulse got=%b exp=1", underflow_o); end
        step(1, 8'h77, 1, 5'd1, 0);
        n_tests++; if (usedw_o !== 5'd1) begin n_fail++; $display("FAIL udf_wr_usedw got=%0d exp=1", usedw_o); end
        n_tests++; if (rddata_o !== 8'h77) begin n_fail++; $display("FAIL udf_wr_data got=%h exp=77", rddata_o); end
        step(0, 8'h00, 0, 5'd0, 0);
        n_tests++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL udf_single got=%b exp=0", underflow_o); end
    endtask

    task automatic test_srst_priority();
        step(1, 8'h99, 1, 5'd1, 1);
        n_tests++; if (usedw_o !== 5'd0) begin n_fail++; $display("FAIL srst_usedw got=%0d exp=0", usedw_o); end
        n_tests++; if ({empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin
            n_fail++; $display("FAIL srst_flags got=%b%b%b%b exp=1100", empty_o, almost_empty_o, full_o, almost_full_o); end
    endtask

    task automatic test_wrap();
        step(0, 8'h00, 0, 5'd0, 1);
        for (int i = 0; i < 14; i++) step(1, 8'(8'h10 + i), 0, 5'd0, 0);
        step(0, 8'h00, 1, 5'd14, 0);
        n_tests++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL wrap_drain got=%b exp=1", empty_o); end
        for (int i = 0; i < 4; i++) step(1, 8'(8'hB0 + i), 0, 5'd0, 0);
        step(0, 8'h00, 1, 5'd3, 0);
        n_tests++; if (rddata_o !== 8'hB3) begin n_fail++; $display("FAIL wrap_data got=%h exp=b3", rddata_o); end
        n_tests++; if (usedw_o !== 5'd1) begin n_fail++; $display("FAIL wrap_usedw got=%0d exp=1", usedw_o); end
    endtask

    task automatic test_async_reset();
        step(0, 8'h00, 0, 5'd0, 1);
        for (int i = 0; i < 7; i++) step(1, 8'(8'hC0 + i), 0, 5'd0, 0);
        #2 arstn_i = 1'b0;
        #1;
        n_tests++; if (usedw_o !== 5'd0) begin n_fail++; $display("FAIL arst_usedw got=%0d exp=0", usedw_o); end
        n_tests++; if ({empty_o, almost_empty_o, full_o, almost_full_o} !== 4'b1100) begin
            n_fail++; $display("FAIL arst_flags got=%b%b%b%b exp=1100", empty_o, almost_empty_o, full_o, almost_full_o); end
        arstn_i = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        step(1, 8'hA5, 0, 5'd0, 0);
        n_tests++; if (rddata_o !== 8'hA5) begin n_fail++; $display("FAIL arst_first got=%h exp=a5", rddata_o); end
        n_tests++; if (usedw_o !== 5'd1) begin n_fail++; $display("FAIL arst_usedw1 got=%0d exp=1", usedw_o); end
    endtask

    task automatic test_random();
        logic [4:0] sk;
        for (int c = 0; c < 600; c++) begin
            sk = 5'($urandom_range(0, 16));
            step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 40), sk,
                 ($urandom_range(0, 199) == 0));
            n_tests++; if (usedw_o !== 5'(q.size())) begin n_fail++; $display("FAIL rnd_usedw c=%0d got=%0d exp=%0d", c, usedw_o, q.size()); end
            n_tests++; if ({empty_o, full_o} !== {q.size() == 0, q.size() == DEPTH}) begin
                n_fail++; $display("FAIL rnd_ef c=%0d got=%b%b exp=%b%b", c, empty_o, full_o, q.size() == 0, q.size() == DEPTH); end
            n_tests++; if ({almost_empty_o, almost_full_o} !== {q.size() <= AE, q.size() >= AF}) begin
                n_fail++; $display("FAIL rnd_almost c=%0d got=%b%b exp=%b%b", c, almost_empty_o, almost_full_o, q.size() <= AE, q.size() >= AF); end
            n_tests++; if ({overflow_o, underflow_o} !== {m_ovf, m_udf}) begin
                n_fail++; $display("FAIL rnd_err c=%0d got=%b%b exp=%b%b", c, overflow_o, underflow_o, m_ovf, m_udf); end
            if (q.size() != 0) begin
                n_tests++; if (rddata_o !== q[0]) begin n_fail++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, rddata_o, q[0]); end
            end
        end
    endtask

    initial begin
        arstn_i  = 1'b1;
        srst_i   = 1'b0;
        wr_i     = 1'b0;
        wrdata_i = 8'h00;
        rd_i     = 1'b0;
        skip_i   = 5'd0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        #2 arstn_i = 1'b0;
        #1;
        test_reset();
        arstn_i = 1'b1;
        test_fill();
        test_skip();
        test_full_rw();
        test_saturate();
        test_srst_priority();
        test_wrap();
        test_async_reset();
        test_random();
        step(0, 8'h00, 0, 5'd0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
